// File: rtl/adder_pkg.sv
// Shared types and constants for the two-operand adder and its downstream collector.
package adder_pkg;

  localparam int SUM_W   = 5;
  localparam int OP_W    = 4;
  localparam int LATENCY = 2;

  typedef logic [SUM_W-1:0] sum_t;

  // One adder result as seen at the FIFO head.
  typedef struct packed {
    sum_t sum;
    logic valid;
  } result_t;

endpackage

// File: rtl/sum_collector_if.sv
// Stream bundle around the collector: adder-side capture inputs and the
// valid/ready result output. The master side is the environment, the slave side
// is the collector.
interface sum_collector_if;

  logic             en_in;
  adder_pkg::sum_t  sum_in;
  logic             out_ready;
  logic             out_valid;
  adder_pkg::sum_t  out_sum;
  logic             out_carry;

  modport master (
    output en_in,
    output sum_in,
    output out_ready,
    input  out_valid,
    input  out_sum,
    input  out_carry
  );

  modport slave (
    input  en_in,
    input  sum_in,
    input  out_ready,
    output out_valid,
    output out_sum,
    output out_carry
  );

endinterface

// File: rtl/sum_collector_sync_fifo.sv
// Small synchronous FIFO with a combinational head output (zero when empty).
// No overflow/underflow protection: the parent only pushes when there is room
// (or a pop happens on the same edge) and only pops when not empty.
module sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    count_reg;

  // Storage write; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks true occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign empty = (count_reg == '0);
  assign full  = (count_reg == LW'(DEPTH));
  assign level = count_reg;
  assign dout  = empty ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/sum_collector.sv
// Downstream stage of the two-operand adder: follows the adder's fixed
// enable-to-sum latency, captures each valid sum into a FIFO, serves it on a
// valid/ready port and keeps running statistics of consumed and dropped sums.
module sum_collector #(
  parameter int LATENCY = adder_pkg::LATENCY,
  parameter int DEPTH   = 4,
  parameter int ACC_W   = 12,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  sum_collector_if.slave           bus,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [ACC_W-1:0]         acc,
  output logic                     acc_wrap,
  output logic [CNT_W-1:0]         pop_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     drop_err
);

  import adder_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [LATENCY-1:0] vpipe_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic               acc_wrap_reg;
  logic [CNT_W-1:0]   pop_cnt_reg;
  logic [CNT_W-1:0]   drop_cnt_reg;
  logic               drop_err_reg;

  logic               capture;
  logic               pop;
  logic               push;
  logic               drop;
  logic               full;
  logic               empty;
  sum_t               head_sum;
  result_t            head;
  logic [LVL_W-1:0]   level;
  logic [ACC_W:0]     acc_next;

  // Valid pipe mirroring the adder's register stages; a bit leaving the end
  // marks the cycle whose closing edge samples a valid sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe_reg <= '0;
    end else begin
      vpipe_reg[0] <= bus.en_in;
      for (int i = 1; i < LATENCY; i++) begin
        vpipe_reg[i] <= vpipe_reg[i-1];
      end
    end
  end

  assign capture = vpipe_reg[LATENCY-1];
  assign pop     = head.valid && bus.out_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  sync_fifo #(
    .WIDTH (SUM_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.sum_in),
    .dout  (head_sum),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Head entry view; the FIFO already returns zero when empty.
  always_comb begin
    head       = '0;
    head.sum   = head_sum;
    head.valid = !empty;
  end

  assign bus.out_valid = head.valid;
  assign bus.out_sum   = head.sum;
  assign bus.out_carry = head.sum[SUM_W-1];
  assign fifo_level    = level;

  // One extra bit exposes the carry out of the accumulator.
  assign acc_next = {1'b0, acc_reg} + (ACC_W+1)'(head.sum);

  // Statistics on consumed and dropped results.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg      <= '0;
      acc_wrap_reg <= 1'b0;
      pop_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
      drop_err_reg <= 1'b0;
    end else begin
      if (pop) begin
        acc_reg     <= acc_next[ACC_W-1:0];
        pop_cnt_reg <= pop_cnt_reg + CNT_W'(1);
        if (acc_next[ACC_W]) acc_wrap_reg <= 1'b1;
      end
      if (drop) begin
        drop_err_reg <= 1'b1;
        if (drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign acc      = acc_reg;
  assign acc_wrap = acc_wrap_reg;
  assign pop_cnt  = pop_cnt_reg;
  assign drop_cnt = drop_cnt_reg;
  assign drop_err = drop_err_reg;

endmodule

// File: tb/tb_sum_collector.sv
// Directed + randomized bench for sum_collector against a queue-based model.
module tb_sum_collector;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int ACC_W = 12;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       fifo_level;
  logic [ACC_W-1:0] acc;
  logic             acc_wrap;
  logic [CNT_W-1:0] pop_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             drop_err;

  sum_collector_if bus ();

  sum_collector #(
    .LATENCY (LAT),
    .DEPTH   (DEPTH),
    .ACC_W   (ACC_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fifo_level (fifo_level),
    .acc        (acc),
    .acc_wrap   (acc_wrap),
    .pop_cnt    (pop_cnt),
    .drop_cnt   (drop_cnt),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  // Reference model: results waiting to be consumed, and the edge numbers at
  // which enables were accepted (a sum is due LAT edges later).
  int m_fifo[$];
  int m_en[$];
  int m_edge = 0;
  int m_acc  = 0;
  bit m_wrap = 0;
  int m_pop  = 0;
  int m_drop = 0;
  bit m_err  = 0;
  bit m_popped;
  int m_popped_val;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit en, input int s, input bit rdy, input bit r);
    bit pop;
    bit cap;
    m_popped = 0;
    if (r) begin
      m_fifo.delete();
      m_en.delete();
      m_acc  = 0;
      m_wrap = 0;
      m_pop  = 0;
      m_drop = 0;
      m_err  = 0;
    end else begin
      pop = (m_fifo.size() > 0) && rdy;
      cap = 0;
      if (m_en.size() > 0 && m_en[0] == m_edge - LAT) begin
        cap = 1;
        void'(m_en.pop_front());
      end
      if (cap && m_fifo.size() == DEPTH && !pop) begin
        if (m_drop < 255) m_drop++;
        m_err = 1;
        cap = 0;
      end
      if (pop) begin
        m_popped_val = m_fifo.pop_front();
        m_popped = 1;
        m_acc = m_acc + m_popped_val;
        if (m_acc >= 4096) begin
          m_acc  = m_acc - 4096;
          m_wrap = 1;
        end
        m_pop = (m_pop + 1) % 256;
      end
      if (cap) m_fifo.push_back(s);
      if (en) m_en.push_back(m_edge);
    end
    m_edge++;
  endtask

  task automatic check_all();
    int head;
    head = (m_fifo.size() > 0) ? m_fifo[0] : 0;
    chk("out_valid",  bus.out_valid, (m_fifo.size() > 0) ? 1 : 0);
    chk("out_sum",    bus.out_sum,   head);
    chk("out_carry",  bus.out_carry, (head >> 4) & 1);
    chk("fifo_level", fifo_level,    m_fifo.size());
    chk("acc",        acc,           m_acc);
    chk("acc_wrap",   acc_wrap,      m_wrap);
    chk("pop_cnt",    pop_cnt,       m_pop);
    chk("drop_cnt",   drop_cnt,      m_drop);
    chk("drop_err",   drop_err,      m_err);
  endtask

  // One clock transaction: drive, clock, advance model, compare.
  task automatic cyc(input bit en, input int s, input bit rdy, input bit r);
    bus.en_in     = en;
    bus.sum_in    = 5'(s);
    bus.out_ready = rdy;
    rst           = r;
    @(posedge clk);
    model_edge(en, s & 31, rdy, r);
    #1;
    check_all();
    if (m_popped)
      $display("[TB] edge %0d pop sum=%0d acc=%0d level=%0d", m_edge, m_popped_val, acc, fifo_level);
  endtask

  initial begin
    bus.en_in     = 1'b0;
    bus.sum_in    = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;

    // Reset state
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("reset_level", fifo_level, 0);
    chk("reset_valid", bus.out_valid, 0);

    // Single result of 8
    cyc(1, 8, 1, 0);
    cyc(0, 8, 1, 0);
    chk("single_not_yet", bus.out_valid, 0);
    cyc(0, 8, 1, 0);
    chk("single_valid", bus.out_valid, 1);
    chk("single_sum", bus.out_sum, 8);
    cyc(0, 0, 1, 0);
    chk("single_acc", acc, 8);
    chk("single_popcnt", pop_cnt, 1);

    // Carry path with 15+15
    cyc(0, 0, 0, 1);
    cyc(1, 30, 1, 0);
    cyc(0, 30, 1, 0);
    cyc(0, 30, 1, 0);
    chk("carry_sum", bus.out_sum, 30);
    chk("carry_bit", bus.out_carry, 1);
    cyc(0, 0, 1, 0);
    chk("carry_acc", acc, 30);

    // Backpressure and overflow: sums 1..6 with out_ready low
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(i < 6, (i >= 2) ? i - 1 : 0, 0, 0);
    chk("ovf_level", fifo_level, 4);
    chk("ovf_dropcnt", drop_cnt, 2);
    chk("ovf_droperr", drop_err, 1);
    chk("ovf_head", bus.out_sum, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
    chk("ovf_acc", acc, 10);

    // Full FIFO with push and pop on the same edge
    for (int i = 0; i < 6; i++) cyc(1, $urandom_range(0, 31), 0, 0);
    chk("full_level", fifo_level, 4);
    for (int i = 0; i < 4; i++) cyc(1, $urandom_range(0, 31), 1, 0);
    chk("pp_level", fifo_level, 4);
    chk("pp_nodrop", drop_cnt, 2);
    for (int i = 0; i < 8; i++) cyc(0, $urandom_range(0, 31), 1, 0);

    // Accumulator wrap: 137 results of 30
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 137; i++) cyc(1, 30, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 30, 1, 0);
    chk("wrap_acc", acc, 14);
    chk("wrap_flag", acc_wrap, 1);
    chk("wrap_popcnt", pop_cnt, 137);

    // Drop counter saturation
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 270; i++) cyc(1, $urandom_range(0, 31), 0, 0);
    chk("sat_dropcnt", drop_cnt, 255);

    // Mid-stream reset discards in-flight enables
    cyc(0, 0, 0, 1);
    cyc(1, 7, 1, 0);
    cyc(1, 7, 1, 0);
    cyc(0, 7, 1, 1);
    for (int i = 0; i < 4; i++) cyc(0, 7, 1, 0);
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_level", fifo_level, 0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 9) < 7,
          $urandom_range(0, 59) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
